// File: rtl/gate_check_pkg.sv
// Shared constants for the gate vector checker: gate_out bit positions,
// FSM state encoding and the error-counter saturation limit.
package gate_check_pkg;

    localparam int AND_I     = 0;
    localparam int OR_I      = 1;
    localparam int NOT_I     = 2;
    localparam int NAND_I    = 3;
    localparam int NOR_I     = 4;
    localparam int XOR_I     = 5;
    localparam int XNOR_I    = 6;
    localparam int NUM_GATES = 7;

    localparam logic [7:0] ERR_MAX = 8'd255;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/gate_ref_model.sv
// Golden two-input gate model: the response a correct logic_gates block
// must produce for stimulus (a,b).
module gate_ref_model
    import gate_check_pkg::*;
(
    input  logic                 a,
    input  logic                 b,
    output logic [NUM_GATES-1:0] expected
);

    always_comb begin
        expected         = '0;
        expected[AND_I]  = a & b;
        expected[OR_I]   = a | b;
        expected[NOT_I]  = ~a;
        expected[NAND_I] = ~(a & b);
        expected[NOR_I]  = ~(a | b);
        expected[XOR_I]  = a ^ b;
        expected[XNOR_I] = ~(a ^ b);
    end

endmodule

// File: rtl/gate_vector_checker.sv
// Sweeps (a,b) through all four vectors NUM_PASSES times, checks the gate
// block response against gate_ref_model and reports pass/error count/first failure.
module gate_vector_checker
    import gate_check_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int NUM_PASSES    = 1
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 a,
    output logic                 b,
    input  logic [NUM_GATES-1:0] gate_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [7:0]           err_count,
    output logic [1:0]           fail_vec,
    output logic [NUM_GATES-1:0] fail_mask
);

    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PCW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [SCW-1:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SCW'(SETTLE_CYCLES - 1) : SCW'(0);
    localparam logic [PCW-1:0] LAST_PASS   = PCW'(NUM_PASSES - 1);

    state_t               state_q, state_d;
    logic [1:0]           vec_q, vec_d;
    logic [PCW-1:0]       pass_cnt_q, pass_cnt_d;
    logic [SCW-1:0]       settle_q, settle_d;
    logic [1:0]           ab_q, ab_d;
    logic [7:0]           err_q, err_d;
    logic [1:0]           fvec_q, fvec_d;
    logic [NUM_GATES-1:0] fmask_q, fmask_d;
    logic                 pass_q, pass_d;

    logic [NUM_GATES-1:0] expected;
    logic [NUM_GATES-1:0] diff;
    logic                 mismatch;

    gate_ref_model u_ref (
        .a        (ab_q[1]),
        .b        (ab_q[0]),
        .expected (expected)
    );

    // Case inequality so that X/Z on gate_out is reported as a failure.
    assign mismatch = (gate_out !== expected);
    assign diff     = gate_out ^ expected;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            pass_cnt_q <= '0;
            settle_q   <= '0;
            ab_q       <= '0;
            err_q      <= '0;
            fvec_q     <= '0;
            fmask_q    <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            pass_cnt_q <= pass_cnt_d;
            settle_q   <= settle_d;
            ab_q       <= ab_d;
            err_q      <= err_d;
            fvec_q     <= fvec_d;
            fmask_q    <= fmask_d;
            pass_q     <= pass_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        pass_cnt_d = pass_cnt_q;
        settle_d   = settle_q;
        ab_d       = ab_q;
        err_d      = err_q;
        fvec_d     = fvec_q;
        fmask_d    = fmask_q;
        pass_d     = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = DRIVE;
                    err_d      = '0;
                    fvec_d     = '0;
                    fmask_d    = '0;
                    pass_d     = 1'b0;
                    vec_d      = '0;
                    pass_cnt_d = '0;
                end
            end
            DRIVE: begin
                ab_d = vec_q;
                if (SETTLE_CYCLES == 0) begin
                    state_d = CHECK;
                end else begin
                    state_d  = SETTLE;
                    settle_d = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (settle_q == '0) state_d = CHECK;
                else                settle_d = settle_q - 1'b1;
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) err_d = err_q + 8'd1;
                    // err_count never returns to zero mid-run, so zero marks the first failure.
                    if (err_q == '0) begin
                        fvec_d  = ab_q;
                        fmask_d = diff;
                    end
                end
                if (vec_q == 2'b11 && pass_cnt_q == LAST_PASS) begin
                    state_d = DONE;
                end else begin
                    vec_d = vec_q + 2'd1;
                    if (vec_q == 2'b11) pass_cnt_d = pass_cnt_q + 1'b1;
                    state_d = DRIVE;
                end
            end
            DONE: begin
                pass_d  = (err_q == '0);
                ab_d    = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign a         = ab_q[1];
    assign b         = ab_q[0];
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fvec_q;
    assign fail_mask = fmask_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench for gate_vector_checker: three instances (default, two passes,
// no settle) each driving a behavioural gate block with an optional xor stuck-at-0.
module tb_gate_vector_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start_w [3];
    logic       xor_stuck [3];
    logic       a_w [3];
    logic       b_w [3];
    logic       busy_w [3];
    logic       done_w [3];
    logic       pass_w [3];
    logic [7:0] err_w [3];
    logic [1:0] fv_w [3];
    logic [6:0] fm_w [3];
    logic [6:0] gout [3];

    int checks = 0;
    int errors = 0;

    function automatic logic [6:0] gates(input logic a, input logic b, input logic stuck);
        return {~(a ^ b), (stuck ? 1'b0 : (a ^ b)), ~(a | b), ~(a & b), ~a, (a | b), (a & b)};
    endfunction

    always_comb gout[0] = gates(a_w[0], b_w[0], xor_stuck[0]);
    always_comb gout[1] = gates(a_w[1], b_w[1], xor_stuck[1]);
    always_comb gout[2] = gates(a_w[2], b_w[2], xor_stuck[2]);

    gate_vector_checker #(.SETTLE_CYCLES(1), .NUM_PASSES(1)) u0 (
        .clk(clk), .rst(rst), .start(start_w[0]), .a(a_w[0]), .b(b_w[0]),
        .gate_out(gout[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(err_w[0]), .fail_vec(fv_w[0]), .fail_mask(fm_w[0]));

    gate_vector_checker #(.SETTLE_CYCLES(1), .NUM_PASSES(2)) u1 (
        .clk(clk), .rst(rst), .start(start_w[1]), .a(a_w[1]), .b(b_w[1]),
        .gate_out(gout[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(err_w[1]), .fail_vec(fv_w[1]), .fail_mask(fm_w[1]));

    gate_vector_checker #(.SETTLE_CYCLES(0), .NUM_PASSES(1)) u2 (
        .clk(clk), .rst(rst), .start(start_w[2]), .a(a_w[2]), .b(b_w[2]),
        .gate_out(gout[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .err_count(err_w[2]), .fail_vec(fv_w[2]), .fail_mask(fm_w[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Results of the most recent run_inst call.
    int         first_done;
    int         ndone;
    logic [1:0] ab_log [64];
    logic       rs_busy, rs_a, rs_b, rs_done;
    logic [7:0] rs_err, pre_err;
    logic [1:0] rs_fv;
    logic [6:0] rs_fm;

    // Pulses start into edge 0, then observes ncyc edges (sampled #1 after each).
    // restart_at: edge at which start is pulsed again; rst_at: edge after which rst rises.
    task automatic run_inst(input int k, input int ncyc, input int restart_at, input int rst_at);
        first_done = -1;
        ndone      = 0;
        @(negedge clk);
        start_w[k] = 1'b1;
        @(posedge clk);
        #1;
        start_w[k] = 1'b0;
        for (int n = 1; n <= ncyc; n++) begin
            start_w[k] = (n == restart_at);
            if (n == rst_at + 3) rst = 1'b0;
            @(posedge clk);
            #1;
            if (n == rst_at) begin
                pre_err = err_w[k];
                rst = 1'b1;
                #1;
                rs_busy = busy_w[k];
                rs_a    = a_w[k];
                rs_b    = b_w[k];
                rs_done = done_w[k];
                rs_err  = err_w[k];
                rs_fv   = fv_w[k];
                rs_fm   = fm_w[k];
            end
            ab_log[n] = {a_w[k], b_w[k]};
            if (done_w[k]) begin
                ndone++;
                if (first_done < 0) first_done = n + 1;
            end
        end
        start_w[k] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_w[i]   = 1'b0;
            xor_stuck[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy_w[0], 1'b0);
        chk("rst_done", done_w[0], 1'b0);
        chk("rst_pass", pass_w[0], 1'b0);
        chk("rst_err", err_w[0], 8'd0);
        chk("rst_ab", {a_w[0], b_w[0]}, 2'b00);
        chk("rst_fmask", fm_w[1], 7'd0);
        @(negedge clk);
        rst = 1'b0;

        // Correct gates, default parameters
        run_inst(0, 30, -1, -1);
        chk("t1_done_edge", first_done, 13);
        chk("t1_ndone", ndone, 1);
        chk("t1_pass", pass_w[0], 1'b1);
        chk("t1_err", err_w[0], 8'd0);
        chk("t1_ab1", ab_log[1], 2'b00);
        chk("t1_ab4", ab_log[4], 2'b01);
        chk("t1_ab7", ab_log[7], 2'b10);
        chk("t1_ab10", ab_log[10], 2'b11);
        chk("t1_ab13", ab_log[13], 2'b00);
        chk("t1_busy_end", busy_w[0], 1'b0);

        // xor stuck at 0
        xor_stuck[0] = 1'b1;
        run_inst(0, 30, -1, -1);
        chk("t2_done_edge", first_done, 13);
        chk("t2_err", err_w[0], 8'd2);
        chk("t2_fvec", fv_w[0], 2'b01);
        chk("t2_fmask", fm_w[0], 7'b0100000);
        chk("t2_pass", pass_w[0], 1'b0);

        // Two passes with xor stuck at 0
        xor_stuck[1] = 1'b1;
        run_inst(1, 40, -1, -1);
        chk("t3_done_edge", first_done, 25);
        chk("t3_ndone", ndone, 1);
        chk("t3_err", err_w[1], 8'd4);
        chk("t3_fvec", fv_w[1], 2'b01);
        chk("t3_fmask", fm_w[1], 7'b0100000);

        // No settle cycles, correct gates
        run_inst(2, 20, -1, -1);
        chk("t4_done_edge", first_done, 9);
        chk("t4_ab1", ab_log[1], 2'b00);
        chk("t4_ab3", ab_log[3], 2'b01);
        chk("t4_ab5", ab_log[5], 2'b10);
        chk("t4_ab7", ab_log[7], 2'b11);
        chk("t4_pass", pass_w[2], 1'b1);

        // start pulsed while busy is ignored
        run_inst(0, 30, 4, -1);
        chk("t6_ndone", ndone, 1);
        chk("t6_done_edge", first_done, 13);
        chk("t6_err", err_w[0], 8'd2);

        // Reset mid-run aborts without a done pulse
        run_inst(0, 30, -1, 6);
        chk("t5_pre_err", pre_err, 8'd1);
        chk("t5_busy", rs_busy, 1'b0);
        chk("t5_ab", {rs_a, rs_b}, 2'b00);
        chk("t5_done", rs_done, 1'b0);
        chk("t5_err", rs_err, 8'd0);
        chk("t5_fvec", rs_fv, 2'b00);
        chk("t5_fmask", rs_fm, 7'd0);
        chk("t5_ndone", ndone, 0);
        chk("t5_pass", pass_w[0], 1'b0);

        xor_stuck[0] = 1'b0;
        run_inst(0, 30, -1, -1);
        chk("t5_rerun_done", first_done, 13);
        chk("t5_rerun_pass", pass_w[0], 1'b1);
        chk("t5_rerun_err", err_w[0], 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
